instr_ram_param: RTL and testbench
==================================

INSTR_RAM_PARAM -- requirements
Module: instr_ram_param

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words; any value 1..65536.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0, word-aligned.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter FILL_WORD, default 32'h0000_0013 (NOP), value written to every word during init.
REQ-005 SHALL have parameter OOR_WORD, default 32'h0000_0000, read data returned for out-of-range addresses.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port bus  naive_bus.slave  --  rd_req/rd_gnt/rd_addr[31:0]/rd_data[31:0], wr_req/wr_gnt/wr_addr[31:0]/wr_be[3:0]/wr_data[31:0].
REQ-009 SHALL have port init_done  output  1  high once the init fill has completed.

Function
REQ-010 FSM states: INIT, READY; reset enters INIT with fill counter 0.
REQ-011 INIT: write FILL_WORD at word[cnt] each cycle, cnt+1; after word DEPTH-1 go to READY, init_done=1 next cycle; INIT lasts exactly DEPTH cycles.
REQ-012 INIT: rd_gnt=0 and wr_gnt=0 regardless of requests; rd_data=0.
REQ-013 READY: rd_gnt=rd_req and wr_gnt=wr_req, combinational, same cycle.
REQ-014 Word index = (addr - BASE_ADDR) >> 2, computed in 32 bits; in range iff addr >= BASE_ADDR and index < DEPTH; addr[1:0] ignored.
REQ-015 Granted read at cycle N: rd_data holds mem[index] (or OOR_WORD if out of range) from cycle N+RD_LAT for one cycle.
REQ-016 Pipeline slot with no granted read SHALL present rd_data=0 (bus OR-merge convention).
REQ-017 Back-to-back granted reads SHALL sustain one word per cycle at both latencies.
REQ-018 Granted write: byte lane i of mem[index] updated from wr_data[8i+7:8i] when wr_be[i]=1; wr_be=0000 or out-of-range write granted and discarded.
REQ-019 Read and write to the same word in the same cycle: read returns pre-write data (read-first).
REQ-020 Read issued cycle after a write to that word returns the new data.

Reset
REQ-021 rst held on a rising edge: state=INIT, cnt=0, init_done=0, all rd_data pipeline stages=0, wr_gnt=rd_gnt=0 that cycle.
REQ-022 rst asserted mid-INIT or mid-READY restarts the full fill from word 0; in-flight reads are dropped (rd_data=0).
REQ-023 Memory array contents themselves SHALL NOT be reset except by the fill.

Configuration
REQ-024 Macro INSTR_RAM_WR_EN: when defined, write port, byte-enable logic and INIT fill are compiled in as above.
REQ-025 Without INSTR_RAM_WR_EN: block is read-only ROM loaded at elaboration from FILL_WORD in every word; FSM enters READY one cycle after reset release; wr_gnt=wr_req in READY, writes discarded.

Structure
REQ-026 Shared package instr_mem_pkg SHALL hold typedef word_t (32 bits), typedef be_t (4 bits), enum ram_state_e {INIT, READY}, constant NOP_WORD=32'h0000_0013.
REQ-027 Sub-module instr_ram_rdpipe SHALL implement the RD_LAT-deep rd_data/valid pipeline with zero-fill; memory and FSM stay in top.

Verification
REQ-028 DEPTH=16, reset then idle: init_done rises exactly 17 cycles after rst drop; read word 5 -> 32'h0000_0013.
REQ-029 Write addr BASE+0x8 data 32'hDEADBEEF be=0110, then read 0x8 -> 32'h00ADBE13; with RD_LAT=2 data appears two cycles after grant.
REQ-030 Read addr BASE+DEPTH*4 and addr BASE-4 (BASE=0x100) -> OOR_WORD; write there leaves memory unchanged.
REQ-031 Same-cycle read/write word 3 (old 0x13, new 0x11111111, be=1111) -> read returns 0x13; next read returns 0x11111111.
REQ-032 rst pulsed at fill count 7 of DEPTH=16: init_done stays 0, rd_gnt stays 0 for 16 further cycles, all words read back FILL_WORD.
REQ-033 Ten consecutive reads addrs 0..36 step 4: ten contiguous valid rd_data cycles, no gaps; idle cycle after yields rd_data=0.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory blocks.
package instr_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef enum logic {INIT, READY} ram_state_e;

  localparam word_t NOP_WORD = 32'h0000_0013;

  // Byte address to word index, relative to the base of the region.
  function automatic word_t word_index(input word_t addr, input word_t base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant memory bus with separate read and write channels.
interface naive_bus;
  import instr_mem_pkg::*;

  logic  rd_req;
  logic  rd_gnt;
  word_t rd_addr;
  word_t rd_data;
  logic  wr_req;
  logic  wr_gnt;
  word_t wr_addr;
  be_t   wr_be;
  word_t wr_data;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/instr_ram_rdpipe.sv
// RD_LAT-deep read-data pipeline; slots without a granted read carry zero.
module instr_ram_rdpipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_vld,
  input  word_t i_data,
  output word_t o_data
);

  word_t r_stage [RD_LAT];

  // Zero in idle slots lets several slaves share rd_data through an OR.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_vld ? i_data : '0;
      for (int i = 1; i < int'(RD_LAT); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[RD_LAT-1];

endmodule

// File: rtl/instr_ram_param.sv
// Instruction RAM on a naive_bus slave port with configurable read latency.
// Define INSTR_RAM_WR_EN for the writable RAM with an init fill; otherwise a FILL_WORD ROM.
module instr_ram_param
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter word_t       BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RD_LAT    = 1,
  parameter word_t       FILL_WORD = NOP_WORD,
  parameter word_t       OOR_WORD  = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    rst,
  naive_bus.slave bus,
  output logic    init_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_state_e r_state;
  ram_state_e w_state_nxt;
  logic       r_init_done;
  logic       w_rd_gnt;
  logic       w_wr_gnt;
  word_t      w_rd_idx;
  logic       w_rd_in_range;
  word_t      w_rd_word;
  word_t      w_rd_data;

  assign w_rd_idx      = word_index(bus.rd_addr, BASE_ADDR);
  assign w_rd_in_range = (bus.rd_addr >= BASE_ADDR) && (w_rd_idx < DEPTH);

`ifdef INSTR_RAM_WR_EN
  logic [AW-1:0] r_cnt;
  word_t         w_wr_idx;
  logic          w_wr_in_range;
  word_t         r_mem [DEPTH];

  assign w_wr_idx      = word_index(bus.wr_addr, BASE_ADDR);
  assign w_wr_in_range = (bus.wr_addr >= BASE_ADDR) && (w_wr_idx < DEPTH);

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
  end

  // NOTE: the array has no reset branch on purpose; a reset term turns it into flops and the fill already initialises every word.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_cnt] <= FILL_WORD;
    end else if (w_wr_gnt && w_wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wr_be[i]) r_mem[w_wr_idx[AW-1:0]][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  // Combinational read ahead of the write edge gives read-first behaviour.
  assign w_rd_word = w_rd_in_range ? r_mem[w_rd_idx[AW-1:0]] : OOR_WORD;
`else
  logic w_unused;

  assign w_unused  = ^{bus.wr_addr, bus.wr_be, bus.wr_data};
  assign w_rd_word = w_rd_in_range ? FILL_WORD : OOR_WORD;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (r_state == READY);
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_gnt    = 1'b0;
    w_wr_gnt    = 1'b0;
    case (r_state)
      INIT: begin
`ifdef INSTR_RAM_WR_EN
        if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = READY;
`else
        w_state_nxt = READY;
`endif
      end
      READY: begin
        w_rd_gnt = bus.rd_req & ~rst;
        w_wr_gnt = bus.wr_req & ~rst;
      end
      default: w_state_nxt = INIT;
    endcase
  end

  instr_ram_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_gnt),
    .i_data (w_rd_word),
    .o_data (w_rd_data)
  );

  assign bus.rd_gnt  = w_rd_gnt;
  assign bus.wr_gnt  = w_wr_gnt;
  assign bus.rd_data = w_rd_data;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_instr_ram_param.sv
// Scoreboard bench for instr_ram_param: one instance at RD_LAT=1 and one at RD_LAT=2 share stimulus.
module tb_instr_ram_param;
  import instr_mem_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam word_t       BASE  = 32'h0000_0100;
  localparam word_t       OOR   = 32'hBAD0_BAD0;
`ifdef INSTR_RAM_WR_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif
  localparam int INIT_CYC = WR ? int'(DEPTH) : 1;

  typedef struct packed {
    int unsigned due;
    word_t       data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rd_req;
  word_t       rd_addr;
  logic        wr_req;
  word_t       wr_addr;
  be_t         wr_be;
  word_t       wr_data;
  logic        init_done1;
  logic        init_done2;
  logic        mon_en;
  int unsigned cyc;
  int          n_checks;
  int          n_err;
  exp_t        q1[$];
  exp_t        q2[$];

  naive_bus bus1();
  naive_bus bus2();

  assign bus1.rd_req  = rd_req;
  assign bus1.rd_addr = rd_addr;
  assign bus1.wr_req  = wr_req;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_be   = wr_be;
  assign bus1.wr_data = wr_data;
  assign bus2.rd_req  = rd_req;
  assign bus2.rd_addr = rd_addr;
  assign bus2.wr_req  = wr_req;
  assign bus2.wr_addr = wr_addr;
  assign bus2.wr_be   = wr_be;
  assign bus2.wr_data = wr_data;

  instr_ram_param #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(1), .FILL_WORD(NOP_WORD), .OOR_WORD(OOR)
  ) u_dut_lat1 (
    .clk(clk), .rst(rst), .bus(bus1), .init_done(init_done1)
  );

  instr_ram_param #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(2), .FILL_WORD(NOP_WORD), .OOR_WORD(OOR)
  ) u_dut_lat2 (
    .clk(clk), .rst(rst), .bus(bus2), .init_done(init_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: a queued entry is due on its cycle; every other cycle must read zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q1.size() != 0 && q1[0].due == cyc) begin
        check("lat1 rd_data", bus1.rd_data, q1[0].data);
        q1.delete(0);
      end else begin
        check("lat1 idle rd_data", bus1.rd_data, 32'h0);
      end
      if (q2.size() != 0 && q2[0].due == cyc) begin
        check("lat2 rd_data", bus2.rd_data, q2[0].data);
        q2.delete(0);
      end else begin
        check("lat2 idle rd_data", bus2.rd_data, 32'h0);
      end
    end
  end

  function automatic word_t ev(input word_t wr_val);
    return WR ? wr_val : NOP_WORD;
  endfunction

  task automatic push(input word_t d);
    exp_t e1;
    exp_t e2;
    e1.due  = cyc + 1;
    e1.data = d;
    e2.due  = cyc + 2;
    e2.data = d;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic idle();
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input word_t addr, input word_t exp_v);
    rd_req  = 1'b1;
    rd_addr = addr;
    wr_req  = 1'b0;
    push(exp_v);
    #1;
    check("lat1 rd_gnt", 32'(bus1.rd_gnt), 32'd1);
    check("lat2 rd_gnt", 32'(bus2.rd_gnt), 32'd1);
    @(negedge clk);
  endtask

  task automatic wr(input word_t addr, input word_t data, input be_t be);
    rd_req  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    #1;
    check("lat1 wr_gnt", 32'(bus1.wr_gnt), 32'd1);
    check("lat2 wr_gnt", 32'(bus2.wr_gnt), 32'd1);
    @(negedge clk);
  endtask

  task automatic rdwr(input word_t addr, input word_t data, input be_t be, input word_t exp_v);
    rd_req  = 1'b1;
    rd_addr = addr;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    push(exp_v);
    #1;
    check("rdwr rd_gnt", 32'(bus1.rd_gnt & bus2.rd_gnt), 32'd1);
    check("rdwr wr_gnt", 32'(bus1.wr_gnt & bus2.wr_gnt), 32'd1);
    @(negedge clk);
  endtask

  // Called at the negedge where rst has just dropped; requests are held to prove they are ignored.
  task automatic init_seq(input string tag);
    int n;
    rd_req  = 1'b1;
    rd_addr = BASE;
    wr_req  = 1'b1;
    wr_addr = BASE;
    wr_be   = 4'hF;
    wr_data = 32'hFFFF_FFFF;
    for (int i = 0; i < INIT_CYC; i++) begin
      #1;
      check({tag, " rd_gnt in INIT"}, 32'({bus1.rd_gnt, bus2.rd_gnt}), 32'd0);
      check({tag, " wr_gnt in INIT"}, 32'({bus1.wr_gnt, bus2.wr_gnt}), 32'd0);
      check({tag, " init_done in INIT"}, 32'({init_done1, init_done2}), 32'd0);
      @(negedge clk);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    n = INIT_CYC;
    while (init_done1 !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " init_done latency"}, 32'(n), 32'(INIT_CYC + 1));
    check({tag, " init_done lat2"}, 32'(init_done2), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_be    = '0;
    wr_data  = '0;

    repeat (3) @(negedge clk);
    rd_req = 1'b1;
    wr_req = 1'b1;
    #1;
    check("gnt during reset", 32'({bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt}), 32'd0);
    check("init_done during reset", 32'({init_done1, init_done2}), 32'd0);
    @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;
    init_seq("power-up");

    rd(BASE + 32'h14, NOP_WORD);
    wr(BASE + 32'h8, 32'hDEAD_BEEF, 4'b0110);
    rd(BASE + 32'h8, ev(32'h00AD_BE13));

    rd(BASE + 32'h40, OOR);
    rd(BASE - 32'h4, OOR);
    wr(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
    wr(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h0, NOP_WORD);
    rd(BASE + 32'h3C, NOP_WORD);

    rdwr(BASE + 32'hC, 32'h1111_1111, 4'hF, NOP_WORD);
    rd(BASE + 32'hC, ev(32'h1111_1111));

    rd(BASE + 32'hB, ev(32'h00AD_BE13));
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
    rd(BASE + 32'h10, NOP_WORD);
    wr(BASE + 32'h14, 32'hA1B2_C3D4, 4'b1001);
    idle();

    for (int w = 0; w < 10; w++) begin
      word_t e;
      case (w)
        2:       e = ev(32'h00AD_BE13);
        3:       e = ev(32'h1111_1111);
        5:       e = ev(32'hA100_00D4);
        default: e = NOP_WORD;
      endcase
      rd(BASE + 32'(w) * 32'd4, e);
    end
    repeat (3) idle();

    rst     = 1'b1;
    rd_req  = 1'b1;
    rd_addr = BASE;
    wr_req  = 1'b1;
    #1;
    check("gnt while rst in READY", 32'({bus1.rd_gnt, bus1.wr_gnt, bus2.rd_gnt, bus2.wr_gnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    init_seq("restart");
    for (int w = 0; w < int'(DEPTH); w++) rd(BASE + 32'(w) * 32'd4, NOP_WORD);

    repeat (4) idle();
    check("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
